// File: rtl/id_stage_sb.sv
// ARM decode stage: register file, per-register pending-write scoreboard,
// flag-hazard counter and an elastic valid/ready output register.
module id_stage_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2,
  localparam int RI_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [31:0]       instruction,
  input  logic [3:0]        status,
  input  logic              flag_wb,
  input  logic              wb_en,
  input  logic [RI_W-1:0]   wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [3:0]        alu_cmd,
  output logic [RI_W-1:0]   dest,
  output logic [23:0]       imm24,
  output logic [11:0]       shift_op,
  output logic              status_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_en_out,
  output logic              branch,
  output logic              imm_i
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [CNT_W-1:0]  cnt_nxt [NUM_REGS];
  logic [CNT_W-1:0]  flag_cnt, flag_nxt;
  logic [NUM_REGS-1:0] inc_v, wbd_v, fld_v, cnt_uflow;
  logic flag_uflow;

  logic [3:0] cond, opcode;
  logic [1:0] mode;
  logic i_bit, s_bit;
  logic [RI_W-1:0] rn, rd, rm, src2;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign i_bit  = instruction[25];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign rn     = RI_W'(instruction[19:16]);
  assign rd     = RI_W'(instruction[15:12]);
  assign rm     = RI_W'(instruction[3:0]);

  logic [3:0] alu_d;
  logic wb_d, st_d, mr_d, mw_d, br_d, use1, use2;

  always_comb begin
    alu_d = '0;
    wb_d  = 1'b0;
    st_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    br_d  = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    case (mode)
      2'b00: begin
        st_d = s_bit;
        use1 = (opcode != 4'b1101) && (opcode != 4'b1111);
        use2 = ~i_bit;
        wb_d = 1'b1;
        case (opcode)
          4'b1101: alu_d = 4'b0001;
          4'b1111: alu_d = 4'b1001;
          4'b0100: alu_d = 4'b0010;
          4'b0101: alu_d = 4'b0011;
          4'b0010: alu_d = 4'b0100;
          4'b0110: alu_d = 4'b0101;
          4'b0000: alu_d = 4'b0110;
          4'b1100: alu_d = 4'b0111;
          4'b0001: alu_d = 4'b1000;
          4'b1010: begin alu_d = 4'b0100; wb_d = 1'b0; end
          4'b1000: begin alu_d = 4'b0110; wb_d = 1'b0; end
          default: wb_d = 1'b0;
        endcase
      end
      2'b01: begin
        alu_d = 4'b0010;
        use1  = 1'b1;
        if (s_bit) begin
          mr_d = 1'b1;
          wb_d = 1'b1;
        end else begin
          mw_d = 1'b1;
          use2 = 1'b1;
        end
      end
      2'b10:   br_d = 1'b1;
      default: ;
    endcase
  end

  // status = {N, Z, C, V}
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = status[2];
      4'b0001: cond_pass = ~status[2];
      4'b0010: cond_pass = status[1];
      4'b0011: cond_pass = ~status[1];
      4'b0100: cond_pass = status[3];
      4'b0101: cond_pass = ~status[3];
      4'b0110: cond_pass = status[0];
      4'b0111: cond_pass = ~status[0];
      4'b1000: cond_pass = status[1] & ~status[2];
      4'b1001: cond_pass = ~status[1] | status[2];
      4'b1010: cond_pass = (status[3] == status[0]);
      4'b1011: cond_pass = (status[3] != status[0]);
      4'b1100: cond_pass = ~status[2] & (status[3] == status[0]);
      4'b1101: cond_pass = status[2] | (status[3] != status[0]);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign src2 = mw_d ? rd : rm;

  logic [DATA_W-1:0] rd1, rd2;
  assign rd1 = (wb_en && wb_dest == rn)   ? wb_data : regs[rn];
  assign rd2 = (wb_en && wb_dest == src2) ? wb_data : regs[src2];

  logic src1_busy, src2_busy, dest_full, flag_busy, hazard;
  logic issue, undo;
  assign src1_busy = (cnt[rn] - CNT_W'(wb_en && wb_dest == rn)) != '0;
  assign src2_busy = (cnt[src2] - CNT_W'(wb_en && wb_dest == src2)) != '0;
  assign dest_full = wb_d && (cnt[rd] == {CNT_W{1'b1}});
  assign flag_busy = (cond != 4'b1110) && ((flag_cnt - CNT_W'(flag_wb)) != '0);
  assign hazard    = (use1 && src1_busy) || (use2 && src2_busy) || dest_full || flag_busy;
  assign in_ready  = ~hazard & (~out_valid | out_ready) & ~flush;
  assign issue     = in_valid & in_ready & cond_pass;
  // A flushed bundle that EX never took must return its scoreboard claims.
  assign undo      = flush & out_valid & ~out_ready;

  always_comb begin
    inc_v = '0;
    wbd_v = '0;
    fld_v = '0;
    if (issue && wb_d)      inc_v[rd]      = 1'b1;
    if (wb_en)              wbd_v[wb_dest] = 1'b1;
    if (undo && wb_en_out)  fld_v[dest]    = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_nxt[r]   = cnt[r] + CNT_W'(inc_v[r]) - CNT_W'(wbd_v[r]) - CNT_W'(fld_v[r]);
      cnt_uflow[r] = ({1'b0, cnt[r]} + (CNT_W+1)'(inc_v[r]))
                     < ((CNT_W+1)'(wbd_v[r]) + (CNT_W+1)'(fld_v[r]));
    end
    flag_nxt   = flag_cnt + CNT_W'(issue && st_d) - CNT_W'(flag_wb) - CNT_W'(undo && status_en);
    flag_uflow = ({1'b0, flag_cnt} + (CNT_W+1)'(issue && st_d))
                 < ((CNT_W+1)'(flag_wb) + (CNT_W+1)'(undo && status_en));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      flag_cnt  <= '0;
      out_valid <= 1'b0;
      pc        <= '0;
      reg1      <= '0;
      reg2      <= '0;
      alu_cmd   <= '0;
      dest      <= '0;
      imm24     <= '0;
      shift_op  <= '0;
      status_en <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      wb_en_out <= 1'b0;
      branch    <= 1'b0;
      imm_i     <= 1'b0;
    end else begin
      if (wb_en) regs[wb_dest] <= wb_data;
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
      flag_cnt <= flag_nxt;
      if (flush)          out_valid <= 1'b0;
      else if (issue)     out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (issue) begin
        pc        <= pc_in;
        reg1      <= rd1;
        reg2      <= rd2;
        alu_cmd   <= alu_d;
        dest      <= rd;
        imm24     <= instruction[23:0];
        shift_op  <= instruction[11:0];
        status_en <= st_d;
        mem_read  <= mr_d;
        mem_write <= mw_d;
        wb_en_out <= wb_d;
        branch    <= br_d;
        imm_i     <= i_bit;
      end
    end
  end

  cnt_no_underflow: assert property (@(posedge clk) disable iff (rst) cnt_uflow == '0);
  flag_no_underflow: assert property (@(posedge clk) disable iff (rst) !flag_uflow);

endmodule

// File: doc/id_stage_sb.md
# id_stage_sb

Parametrised instruction-decode stage with an integrated register file, per-register write scoreboard, flag-hazard tracking and an elastic output register. It sits between the IF/ID pipeline register and EX. It decodes ARM data-processing, memory and branch instructions using the existing ControlUnit and ConditionCheck mappings. It stalls issue on read-after-write and flag hazards, and hands decoded fields to EX over a valid/ready handshake.

## Interface
- DATA_W, 32, register and PC width
- NUM_REGS, 16, architectural registers; index width RI_W = clog2(NUM_REGS), instruction fields truncated to RI_W
- CNT_W, 2, width of each pending-write counter and of the flag counter
- clk  in  1  clock; everything on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction/pc_in valid
- in_ready  out  1  stage consumes the instruction this cycle
- pc_in  in  DATA_W  PC of instruction
- instruction  in  32  ARM instruction word
- status  in  4  NZCV flags from the status register
- flag_wb  in  1  one-cycle pulse: a status-setting instruction wrote flags
- wb_en  in  1  register write-back strobe
- wb_dest  in  RI_W  write-back register index
- wb_data  in  DATA_W  write-back value
- flush  in  1  discard output register contents (branch taken)
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EX accepts bundle
- pc, reg1, reg2  out  DATA_W  registered PC, Rn value, Rm value (Rd value for STR)
- alu_cmd  out  4, dest  out  RI_W, imm24  out  24, shift_op  out  12
- status_en, mem_read, mem_write, wb_en_out, branch, imm_i  out  1 each

## Operation
- Sources: src1 = Rn, used for mode 00 except opcodes 1101/1111 and for mode 01. src2 = Rd if mem_write, else Rm. src2 is used for mode 00 with I=0 and for STR. Branches use no source.
- Register file: NUM_REGS×DATA_W, written on wb_en. The read is write-first: if wb_en and wb_dest equals the source index, the read returns wb_data.
- Scoreboard: cnt[r] counts issued, not-yet-written-back writes to r. Effective count eff[r] = cnt[r] − (wb_en && wb_dest==r).
- Hazard when any of the following holds:
  - a used source has eff ≠ 0;
  - the instruction writes a register and cnt[dest] is at its maximum, 2^CNT_W−1;
  - flag_cnt_eff ≠ 0 (flag_cnt − flag_wb), since the condition check needs committed flags. Condition AL (1110) is exempt.
- in_ready = in_valid-independent expression: ~hazard & (~out_valid | out_ready) & ~flush.
- Accept (in_valid & in_ready):
  - If the condition passes, load the output register, set out_valid, increment cnt[dest] if wb_en, and increment flag_cnt if status_en.
  - If the condition fails, the instruction is consumed, no bundle is produced, and no counter changes.
- Counter updates from issue, write-back, flag_wb and flush in the same cycle are summed: +1 and −1 on the same entry net to no change.
- flush: out_valid clears next cycle. If the held bundle was valid and not being accepted this cycle, its increments are undone: cnt[dest] −1 if wb_en_out, flag_cnt −1 if status_en. No issue occurs in a flush cycle.
- Underflow is a fatal protocol error (assertion), not masked.

## Timing
- Reset clears all outputs to 0, all counters to 0, all registers to 0, out_valid=0.
- Issue latency is 1 cycle: an instruction accepted at edge N is visible on outputs after N.
- Bundle is held stable while out_valid & ~out_ready.
- A write-back in cycle N clears a RAW hazard for an instruction presented in the same cycle N.
- flag_wb in cycle N releases a conditional instruction in cycle N.
- rst mid-operation has priority over every other input: state is discarded immediately.

## Test plan
- Reset, then ADD R1,R2,R3 with R2=5, R3=7 preloaded via wb → out_valid next cycle, reg1=5, reg2=7, dest=1, cnt[1]=1.
- ADD R1,… followed by SUB R4,R1,R5 → in_ready=0 until wb_en with wb_dest=1, wb_data=0x10; SUB issues that same cycle with reg1=0x10.
- Three ADDs to R2 with no write-back (CNT_W=2) → the fourth write to R2 stalls until one wb_en to R2.
- ADDS then ADDEQ → stall until flag_wb; with status Z=0, ADDEQ is consumed, out_valid stays 0, counters unchanged.
- Issue MOV R6,#1, assert flush with out_ready=0 → out_valid=0 next cycle, cnt[6] back to 0.
- STR R7,[R8]: reg2 reads R7, mem_write=1, wb_en_out=0, cnt unchanged; out_ready held 0 for 3 cycles → outputs stable.
